// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16 controller: states, opcodes/opexts, condition codes,
// flag bit positions, mux selects and the instruction-class decoder.
package cr16_pkg;

   localparam int FLAG_W  = 5;
   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4
   } state_e;

   localparam logic [3:0] OP_REG     = 4'b0000;
   localparam logic [3:0] OP_ANDI    = 4'b0001;
   localparam logic [3:0] OP_ORI     = 4'b0010;
   localparam logic [3:0] OP_XORI    = 4'b0011;
   localparam logic [3:0] OP_SPECIAL = 4'b0100;
   localparam logic [3:0] OP_ADDI    = 4'b0101;
   localparam logic [3:0] OP_SHIFT   = 4'b1000;
   localparam logic [3:0] OP_SUBI    = 4'b1001;
   localparam logic [3:0] OP_CMPI    = 4'b1011;
   localparam logic [3:0] OP_BCOND   = 4'b1100;
   localparam logic [3:0] OP_MOVI    = 4'b1101;
   localparam logic [3:0] OP_LUI     = 4'b1111;

   localparam logic [3:0] EXT_AND   = 4'b0001;
   localparam logic [3:0] EXT_OR    = 4'b0010;
   localparam logic [3:0] EXT_XOR   = 4'b0011;
   localparam logic [3:0] EXT_ADD   = 4'b0101;
   localparam logic [3:0] EXT_SUB   = 4'b1001;
   localparam logic [3:0] EXT_CMP   = 4'b1011;
   localparam logic [3:0] EXT_MOV   = 4'b1101;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JAL   = 4'b1000;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   localparam logic [3:0] CC_EQ = 4'b0000;
   localparam logic [3:0] CC_NE = 4'b0001;
   localparam logic [3:0] CC_CS = 4'b0010;
   localparam logic [3:0] CC_CC = 4'b0011;
   localparam logic [3:0] CC_HI = 4'b0100;
   localparam logic [3:0] CC_LS = 4'b0101;
   localparam logic [3:0] CC_GT = 4'b0110;
   localparam logic [3:0] CC_LE = 4'b0111;
   localparam logic [3:0] CC_FS = 4'b1000;
   localparam logic [3:0] CC_FC = 4'b1001;
   localparam logic [3:0] CC_LO = 4'b1010;
   localparam logic [3:0] CC_HS = 4'b1011;
   localparam logic [3:0] CC_LT = 4'b1100;
   localparam logic [3:0] CC_GE = 4'b1101;
   localparam logic [3:0] CC_UC = 4'b1110;
   localparam logic [3:0] CC_NV = 4'b1111;

   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   localparam logic [1:0] PC_SEL_INC  = 2'b00;
   localparam logic [1:0] PC_SEL_DISP = 2'b01;
   localparam logic [1:0] PC_SEL_RSRC = 2'b10;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM  = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_ALU,
      CLS_CMP,
      CLS_BCOND,
      CLS_JCOND,
      CLS_JAL,
      CLS_LOAD,
      CLS_STOR
   } iclass_e;

   typedef struct packed {
      iclass_e cls;
      logic    sets_flags;
   } instr_dec_t;

   function automatic instr_dec_t decode_instr(input logic [3:0] opcode, input logic [3:0] opext);
      instr_dec_t dec;
      dec.cls        = CLS_NOP;
      dec.sets_flags = 1'b0;
      case (opcode)
         OP_REG: begin
            case (opext)
               EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: dec.cls = CLS_ALU;
               EXT_ADD, EXT_SUB: begin
                  dec.cls        = CLS_ALU;
                  dec.sets_flags = 1'b1;
               end
               EXT_CMP: begin
                  dec.cls        = CLS_CMP;
                  dec.sets_flags = 1'b1;
               end
               default: dec.cls = CLS_NOP;
            endcase
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI, OP_SHIFT: dec.cls = CLS_ALU;
         OP_ADDI, OP_SUBI: begin
            dec.cls        = CLS_ALU;
            dec.sets_flags = 1'b1;
         end
         OP_CMPI: begin
            dec.cls        = CLS_CMP;
            dec.sets_flags = 1'b1;
         end
         OP_SPECIAL: begin
            case (opext)
               EXT_LOAD:  dec.cls = CLS_LOAD;
               EXT_STOR:  dec.cls = CLS_STOR;
               EXT_JAL:   dec.cls = CLS_JAL;
               EXT_JCOND: dec.cls = CLS_JCOND;
               default:   dec.cls = CLS_NOP;
            endcase
         end
         OP_BCOND: dec.cls = CLS_BCOND;
         default:  dec.cls = CLS_NOP;
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Combinational branch/jump condition evaluator: (cond, {C,L,F,Z,N}) -> taken.
// Zero latency, no state, no handshake.
module cr16_cond_eval
   import cr16_pkg::*;
(
   input  logic [3:0]        cond,
   input  logic [FLAG_W-1:0] flags,
   output logic              taken
);

   logic c_flag, l_flag, f_flag, z_flag, n_flag;

   assign c_flag = flags[FLAG_C];
   assign l_flag = flags[FLAG_L];
   assign f_flag = flags[FLAG_F];
   assign z_flag = flags[FLAG_Z];
   assign n_flag = flags[FLAG_N];

   always_comb begin
      taken = 1'b0;
      case (cond)
         CC_EQ: taken = z_flag;
         CC_NE: taken = ~z_flag;
         CC_CS: taken = c_flag;
         CC_CC: taken = ~c_flag;
         CC_HI: taken = l_flag;
         CC_LS: taken = ~l_flag;
         CC_GT: taken = n_flag;
         CC_LE: taken = ~n_flag;
         CC_FS: taken = f_flag;
         CC_FC: taken = ~f_flag;
         CC_LO: taken = ~l_flag & ~z_flag;
         CC_HS: taken = l_flag | z_flag;
         CC_LT: taken = ~n_flag & ~z_flag;
         CC_GE: taken = n_flag | z_flag;
         CC_UC: taken = 1'b1;
         CC_NV: taken = 1'b0;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cr16_control_fsm.sv
// Multi-cycle CR16 sequencer: ALU/branch 3 cycles, STOR 4, LOAD 5, plus memory waits.
// FETCH and MEM hold their request steady until I_MEM_READY; sync reset zeroes all outputs.
module cr16_control_fsm
   import cr16_pkg::*;
#(
   parameter int P_FLAG_WIDTH  = FLAG_W,
   parameter int P_INSTR_WIDTH = INSTR_W
) (
   input  logic                     I_CLK,
   input  logic                     I_RESET,
   input  logic [P_INSTR_WIDTH-1:0] I_INSTR,
   input  logic [P_FLAG_WIDTH-1:0]  I_FLAGS,
   input  logic                     I_MEM_READY,
   output logic                     O_MEM_REQ,
   output logic                     O_MEM_WE,
   output logic                     O_ADDR_SEL,
   output logic                     O_IR_EN,
   output logic                     O_PC_EN,
   output logic [1:0]               O_PC_SEL,
   output logic                     O_RF_WE,
   output logic [1:0]               O_WB_SEL,
   output logic                     O_FLAGS_EN,
   output logic                     O_BRANCH_TAKEN,
   output logic [2:0]               O_STATE
);

   state_e     state_q, state_d;
   instr_dec_t dec;
   logic       cond_taken;
   logic       rsrc_unused;

   // Rsrc only steers the datapath address/PC muxes, never the sequencing.
   assign rsrc_unused = ^I_INSTR[3:0];

   assign dec = decode_instr(I_INSTR[15:12], I_INSTR[7:4]);

   cr16_cond_eval u_cond_eval (
      .cond  (I_INSTR[11:8]),
      .flags (I_FLAGS),
      .taken (cond_taken)
   );

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = ST_FETCH;
      O_MEM_REQ      = 1'b0;
      O_MEM_WE       = 1'b0;
      O_ADDR_SEL     = 1'b0;
      O_IR_EN        = 1'b0;
      O_PC_EN        = 1'b0;
      O_PC_SEL       = PC_SEL_INC;
      O_RF_WE        = 1'b0;
      O_WB_SEL       = WB_SEL_ALU;
      O_FLAGS_EN     = 1'b0;
      O_BRANCH_TAKEN = 1'b0;
      O_STATE        = 3'd0;

      if (!I_RESET) begin
         O_STATE = state_q;
         case (state_q)
            ST_FETCH: begin
               O_MEM_REQ = 1'b1;
               if (I_MEM_READY) begin
                  O_IR_EN = 1'b1;
                  state_d = ST_DECODE;
               end else begin
                  state_d = ST_FETCH;
               end
            end

            ST_DECODE: state_d = ST_EXECUTE;

            ST_EXECUTE: begin
               O_FLAGS_EN = dec.sets_flags;
               case (dec.cls)
                  CLS_ALU: begin
                     O_RF_WE  = 1'b1;
                     O_WB_SEL = WB_SEL_ALU;
                     O_PC_EN  = 1'b1;
                  end
                  CLS_CMP: O_PC_EN = 1'b1;
                  CLS_BCOND: begin
                     O_PC_EN        = 1'b1;
                     O_BRANCH_TAKEN = cond_taken;
                     O_PC_SEL       = cond_taken ? PC_SEL_DISP : PC_SEL_INC;
                  end
                  CLS_JCOND: begin
                     O_PC_EN        = 1'b1;
                     O_BRANCH_TAKEN = cond_taken;
                     O_PC_SEL       = cond_taken ? PC_SEL_RSRC : PC_SEL_INC;
                  end
                  CLS_JAL: begin
                     O_RF_WE  = 1'b1;
                     O_WB_SEL = WB_SEL_LINK;
                     O_PC_EN  = 1'b1;
                     O_PC_SEL = PC_SEL_RSRC;
                  end
                  CLS_LOAD, CLS_STOR: state_d = ST_MEM;
                  default: O_PC_EN = 1'b1;
               endcase
            end

            ST_MEM: begin
               O_MEM_REQ  = 1'b1;
               O_ADDR_SEL = 1'b1;
               O_MEM_WE   = (dec.cls == CLS_STOR);
               if (!I_MEM_READY) begin
                  state_d = ST_MEM;
               end else if (dec.cls == CLS_STOR) begin
                  O_PC_EN = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WRITEBACK;
               end
            end

            ST_WRITEBACK: begin
               O_RF_WE  = 1'b1;
               O_WB_SEL = WB_SEL_MEM;
               O_PC_EN  = 1'b1;
            end

            default: state_d = ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed, table-driven bench for cr16_control_fsm plus a full Bcond condition sweep.
module tb_cr16_control_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic [4:0]  flags;
   logic        rdy;
   logic        mem_req, mem_we, addr_sel, ir_en, pc_en, rf_we, flags_en, br_taken;
   logic [1:0]  pc_sel, wb_sel;
   logic [2:0]  state;
   logic [14:0] act;

   always #5 clk = ~clk;

   cr16_control_fsm #(.P_FLAG_WIDTH(5), .P_INSTR_WIDTH(16)) dut (
      .I_CLK          (clk),
      .I_RESET        (rst),
      .I_INSTR        (instr),
      .I_FLAGS        (flags),
      .I_MEM_READY    (rdy),
      .O_MEM_REQ      (mem_req),
      .O_MEM_WE       (mem_we),
      .O_ADDR_SEL     (addr_sel),
      .O_IR_EN        (ir_en),
      .O_PC_EN        (pc_en),
      .O_PC_SEL       (pc_sel),
      .O_RF_WE        (rf_we),
      .O_WB_SEL       (wb_sel),
      .O_FLAGS_EN     (flags_en),
      .O_BRANCH_TAKEN (br_taken),
      .O_STATE        (state)
   );

   // {req, we, addr_sel, ir_en, pc_en, pc_sel, rf_we, wb_sel, flags_en, taken, state}
   assign act = {mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, rf_we, wb_sel, flags_en, br_taken, state};

   typedef struct {
      logic [15:0] instr;
      logic [4:0]  flags;
      logic        rdy;
      logic        rst;
      logic [14:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [14:0] ev(input logic req, input logic we, input logic asel,
                                      input logic ir, input logic pce, input logic [1:0] pcs,
                                      input logic rfwe, input logic [1:0] wb, input logic fle,
                                      input logic tk, input logic [2:0] st);
      return {req, we, asel, ir, pce, pcs, rfwe, wb, fle, tk, st};
   endfunction

   function automatic logic ref_taken(input logic [3:0] cond, input logic [4:0] fl);
      logic c, l, f, z, n;
      {c, l, f, z, n} = fl;
      case (cond)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return l;
         4'd5:  return !l;
         4'd6:  return n;
         4'd7:  return !n;
         4'd8:  return f;
         4'd9:  return !f;
         4'd10: return !l && !z;
         4'd11: return l || z;
         4'd12: return !n && !z;
         4'd13: return n || z;
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(input logic [15:0] i, input logic [4:0] f, input logic r,
                       input logic rs, input logic [14:0] e, input string nm);
      vec_t v;
      v.instr = i; v.flags = f; v.rdy = r; v.rst = rs; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
   task automatic apply(input vec_t v);
      @(negedge clk);
      instr = v.instr; flags = v.flags; rdy = v.rdy; rst = v.rst;
      #1;
      n_checks++;
      if (act !== v.exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", v.name, act, v.exp);
      end
   endtask

   task automatic fd(input logic [15:0] i, input logic [4:0] f, input string nm);
      push(i, f, 1'b1, 1'b0, ev(1,0,0,1,0,2'b00,0,2'b00,0,0,3'd0), {nm, "_fetch"});
      push(i, f, 1'b0, 1'b0, ev(0,0,0,0,0,2'b00,0,2'b00,0,0,3'd1), {nm, "_decode"});
   endtask

   localparam logic [15:0] I_ADD   = 16'h0152;
   localparam logic [15:0] I_CMP   = 16'h01B2;
   localparam logic [15:0] I_BEQ   = 16'hC005;
   localparam logic [15:0] I_LOAD  = 16'h4304;
   localparam logic [15:0] I_STOR  = 16'h4344;
   localparam logic [15:0] I_JAL   = 16'h4586;
   localparam logic [15:0] I_JNE   = 16'h41C6;
   localparam logic [15:0] I_ADDI  = 16'h5107;
   localparam logic [15:0] I_MOVI  = 16'hD1FF;
   localparam logic [15:0] I_CMPI  = 16'hB10A;
   localparam logic [15:0] I_NOP0  = 16'h0102;
   localparam logic [15:0] I_NOP6  = 16'h6123;

   initial begin
      logic [14:0] e_zero, e_fwait, e_mem_ld, e_mem_st;
      vec_t        v;
      logic        tk;

      rst = 1'b1; instr = I_ADD; flags = 5'd0; rdy = 1'b1;
      e_zero   = 15'd0;
      e_fwait  = ev(1,0,0,0,0,2'b00,0,2'b00,0,0,3'd0);
      e_mem_ld = ev(1,0,1,0,0,2'b00,0,2'b00,0,0,3'd3);
      e_mem_st = ev(1,1,1,0,0,2'b00,0,2'b00,0,0,3'd3);

      push(I_ADD, 5'd0, 1'b1, 1'b1, e_zero, "reset_outputs");
      push(I_ADD, 5'd0, 1'b0, 1'b0, e_fwait, "add_fetch_wait");
      fd(I_ADD, 5'd0, "add");
      push(I_ADD, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,1,2'b00,1,0,3'd2), "add_exec");

      fd(I_CMP, 5'd0, "cmp");
      push(I_CMP, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,0,2'b00,1,0,3'd2), "cmp_exec");
      fd(I_BEQ, 5'b00010, "beq_z");
      push(I_BEQ, 5'b00010, 1'b0, 1'b0, ev(0,0,0,0,1,2'b01,0,2'b00,0,1,3'd2), "beq_taken");
      fd(I_BEQ, 5'd0, "beq_nz");
      push(I_BEQ, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,3'd2), "beq_not_taken");

      fd(I_LOAD, 5'd0, "load");
      push(I_LOAD, 5'd0, 1'b0, 1'b0, e_zero | 15'd2, "load_exec");
      for (int k = 0; k < 3; k++) push(I_LOAD, 5'd0, 1'b0, 1'b0, e_mem_ld, "load_mem_wait");
      push(I_LOAD, 5'd0, 1'b1, 1'b0, e_mem_ld, "load_mem_ready");
      push(I_LOAD, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,1,2'b01,0,0,3'd4), "load_wb");

      fd(I_STOR, 5'd0, "stor");
      push(I_STOR, 5'd0, 1'b0, 1'b0, e_zero | 15'd2, "stor_exec");
      for (int k = 0; k < 2; k++) push(I_STOR, 5'd0, 1'b0, 1'b0, e_mem_st, "stor_mem_wait");
      push(I_STOR, 5'd0, 1'b1, 1'b0, ev(1,1,1,0,1,2'b00,0,2'b00,0,0,3'd3), "stor_mem_ready");

      fd(I_JAL, 5'd0, "jal");
      push(I_JAL, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b10,1,2'b10,0,0,3'd2), "jal_exec");
      fd(I_JNE, 5'd0, "jne_t");
      push(I_JNE, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b10,0,2'b00,0,1,3'd2), "jne_taken");
      fd(I_JNE, 5'b00010, "jne_nt");
      push(I_JNE, 5'b00010, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,3'd2), "jne_not_taken");
      fd(I_ADDI, 5'd0, "addi");
      push(I_ADDI, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,1,2'b00,1,0,3'd2), "addi_exec");
      fd(I_MOVI, 5'd0, "movi");
      push(I_MOVI, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,1,2'b00,0,0,3'd2), "movi_exec");
      fd(I_CMPI, 5'd0, "cmpi");
      push(I_CMPI, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,0,2'b00,1,0,3'd2), "cmpi_exec");
      fd(I_NOP0, 5'd0, "nop0");
      push(I_NOP0, 5'd0, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,3'd2), "nop0_exec");
      fd(I_NOP6, 5'b11111, "nop6");
      push(I_NOP6, 5'b11111, 1'b0, 1'b0, ev(0,0,0,0,1,2'b00,0,2'b00,0,0,3'd2), "nop6_exec");

      // Reset lands on the second MEM wait cycle of a LOAD.
      fd(I_LOAD, 5'd0, "rload");
      push(I_LOAD, 5'd0, 1'b0, 1'b0, e_zero | 15'd2, "rload_exec");
      push(I_LOAD, 5'd0, 1'b0, 1'b0, e_mem_ld, "rload_mem_wait");
      push(I_LOAD, 5'd0, 1'b0, 1'b1, e_zero, "rload_reset_in_mem");
      push(I_LOAD, 5'd0, 1'b0, 1'b0, e_fwait, "rload_after_reset");

      foreach (vecs[i]) apply(vecs[i]);

      // Finish the pending fetch so the sweep starts from a clean FETCH.
      fd(I_ADD, 5'd0, "drain");
      apply(vecs[vecs.size()-2]);
      apply(vecs[vecs.size()-1]);
      v.rdy = 1'b0; v.rst = 1'b0; v.instr = I_ADD; v.flags = 5'd0;
      v.exp = ev(0,0,0,0,1,2'b00,1,2'b00,1,0,3'd2); v.name = "drain_exec";
      apply(v);

      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 32; f++) begin
            v.instr = {4'b1100, 4'(c), 8'h10};
            v.flags = 5'(f);
            v.rst   = 1'b0;
            v.rdy   = 1'b1;
            v.exp   = ev(1,0,0,1,0,2'b00,0,2'b00,0,0,3'd0);
            v.name  = $sformatf("sweep_fetch_c%0d_f%0d", c, f);
            apply(v);
            v.rdy  = 1'b0;
            v.exp  = ev(0,0,0,0,0,2'b00,0,2'b00,0,0,3'd1);
            v.name = $sformatf("sweep_decode_c%0d_f%0d", c, f);
            apply(v);
            tk     = ref_taken(4'(c), 5'(f));
            v.exp  = ev(0,0,0,0,1,tk ? 2'b01 : 2'b00,0,2'b00,0,tk,3'd2);
            v.name = $sformatf("sweep_bcond_c%0d_f%0d", c, f);
            apply(v);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cr16_control_fsm.md
Name: cr16_control_fsm

Overview:
Multi-cycle sequencer for the CR16 datapath: fetch, decode, execute, memory and writeback.
- Generates the enables for the PC, instruction register, register file and the 5-bit flags register.
- Evaluates branch/jump conditions against the registered flags.
- Performs a ready-based handshake with the unified instruction/data memory.
- Sits between the instruction register output and the datapath control inputs.

Parameters:
P_FLAG_WIDTH, 5, width of flags bus; fixed bit order {C,L,F,Z,N} = bits 4..0
P_INSTR_WIDTH, 16, instruction width

Ports:
I_CLK  input  1  clock, all state changes on rising edge
I_RESET  input  1  synchronous, active-high reset
I_INSTR  input  16  current instruction register contents: [15:12] opcode, [11:8] Rdest/cond, [7:4] opext, [3:0] Rsrc
I_FLAGS  input  5  registered flags {C,L,F,Z,N}
I_MEM_READY  input  1  memory completes the current request this cycle
O_MEM_REQ  output  1  memory request valid
O_MEM_WE  output  1  write strobe, qualified by O_MEM_REQ
O_ADDR_SEL  output  1  memory address: 0=PC, 1=Rsrc register
O_IR_EN  output  1  load instruction register
O_PC_EN  output  1  load PC
O_PC_SEL  output  2  00=PC+1, 01=PC+sign-extended disp, 10=Rsrc, 11=unused
O_RF_WE  output  1  register file write to Rdest
O_WB_SEL  output  2  00=ALU, 01=memory data, 10=PC+1 (link)
O_FLAGS_EN  output  1  flags register enable
O_BRANCH_TAKEN  output  1  condition result, valid in EXECUTE
O_STATE  output  3  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4. Codes 5-7 are illegal and go to FETCH.
- Reset:
  - While I_RESET is high at a clock edge, the next state is FETCH, whatever the current state (mid-MEM included). No PC, RF or flags update occurs.
  - While I_RESET is asserted, every output is 0, including O_STATE.
- Outputs are combinational from the state, I_INSTR, I_FLAGS and I_MEM_READY. Any output not listed for a state is 0.
- FETCH:
  - O_MEM_REQ=1, O_ADDR_SEL=0.
  - Hold in FETCH while I_MEM_READY=0.
  - When I_MEM_READY=1: O_IR_EN=1, next state DECODE.
- DECODE: one cycle, no enables asserted (register file read settles); next state EXECUTE.
- EXECUTE, by instruction class:
  - ALU class (reg ops opcode 0000 with opext AND/OR/XOR/ADD/SUB/MOV; immediates ANDI/ORI/XORI/ADDI/SUBI/MOVI/LUI; shifts 1000): O_RF_WE=1, O_WB_SEL=00, O_PC_EN=1, O_PC_SEL=00. Next state FETCH.
  - Flag setting: O_FLAGS_EN=1 only for ADD, ADDI, SUB, SUBI, CMP, CMPI.
  - CMP/CMPI: O_RF_WE=0.
  - Bcond (1100): O_PC_EN=1, O_PC_SEL=01 if taken, else 00. Next state FETCH.
  - Jcond (0100, opext 1100): O_PC_EN=1, O_PC_SEL=10 if taken, else 00. Next state FETCH.
  - JAL (0100, opext 1000): O_RF_WE=1, O_WB_SEL=10, O_PC_EN=1, O_PC_SEL=10. Next state FETCH.
  - LOAD (0100/0000) and STOR (0100/0100): no enables; next state MEM.
  - Any unrecognised encoding: treated as NOP (O_PC_EN=1, O_PC_SEL=00); next state FETCH.
- Branch conditions (cond = I_INSTR[11:8]):
  - EQ Z; NE !Z; CS C; CC !C; HI L; LS !L; GT N; LE !N
  - FS F; FC !F; LO !L&!Z; HS L|Z; LT !N&!Z; GE N|Z
  - UC = 1; 1111 = never taken.
- MEM:
  - O_MEM_REQ=1, O_ADDR_SEL=1. O_MEM_WE=1 for STOR. Request and write strobe are held stable until I_MEM_READY=1.
  - On ready for STOR: O_PC_EN=1, O_PC_SEL=00; next state FETCH.
  - On ready for LOAD: next state WRITEBACK.
- WRITEBACK: O_RF_WE=1, O_WB_SEL=01, O_PC_EN=1, O_PC_SEL=00; next state FETCH.
- Invariants:
  - O_FLAGS_EN is asserted only in EXECUTE and for at most one cycle per instruction.
  - O_PC_EN is asserted exactly once per instruction.
- Latency: ALU and branch instructions take 3 cycles plus fetch wait. LOAD takes 5 cycles plus waits; STOR takes 4 cycles plus waits.

Decomposition:
- Shared package cr16_pkg holds:
  - state encodings;
  - opcode and opext constants;
  - the 4-bit condition codes;
  - flag bit indices C=4, L=3, F=2, Z=1, N=0;
  - the PC_SEL and WB_SEL encodings.
- One natural sub-module, cr16_cond_eval: combinational (cond, flags) -> taken. It is reused by any later pipelined controller.

Test Plan:
- ADD R1,R2 with memory ready immediately: states 0,1,2 over 3 cycles; O_RF_WE=1, O_FLAGS_EN=1 and O_PC_EN=1 in EXECUTE only.
- CMP, then flags=5'b00010, BEQ: O_BRANCH_TAKEN=1, O_PC_SEL=01. With flags=0: taken=0, O_PC_SEL=00. O_RF_WE=0 for the CMP.
- LOAD with I_MEM_READY low for 3 MEM cycles: O_MEM_REQ=1 and O_ADDR_SEL=1 held 4 cycles; then WRITEBACK with O_WB_SEL=01 and O_RF_WE=1.
- STOR with 2 wait cycles: O_MEM_WE=1 for 3 cycles; O_PC_EN=1 on the ready cycle; no WRITEBACK state.
- Assert I_RESET during the second MEM wait cycle: all outputs 0 while reset is high; O_STATE=0 after the edge; no O_RF_WE or O_PC_EN pulse.
- Sweep all 16 condition codes over all 32 flag values with Bcond: taken matches the condition table; 1110 always taken; 1111 never taken.
